// File: rtl/avm_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between two requesters, one transaction in flight.
// Define ARB_TIMEOUT_EN to add the read-response watchdog (TIMEOUT_CYCLES) and sticky timeout_flag.
module avm_master_arbiter #(
    parameter int unsigned ADDRESSWIDTH   = 26,
    parameter int unsigned DATAWIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDRESSWIDTH-1:0] r0_address,
    input  logic [DATAWIDTH-1:0]    r0_writedata,
    input  logic                    r0_read,
    input  logic                    r0_write,
    output logic                    r0_waitrequest,
    output logic [DATAWIDTH-1:0]    r0_readdata,
    output logic                    r0_readdatavalid,
    input  logic [ADDRESSWIDTH-1:0] r1_address,
    input  logic [DATAWIDTH-1:0]    r1_writedata,
    input  logic                    r1_read,
    input  logic                    r1_write,
    output logic                    r1_waitrequest,
    output logic [DATAWIDTH-1:0]    r1_readdata,
    output logic                    r1_readdatavalid,
    output logic [ADDRESSWIDTH-1:0] master_address,
    output logic [DATAWIDTH-1:0]    master_writedata,
    output logic                    master_read,
    output logic                    master_write,
    input  logic [DATAWIDTH-1:0]    master_readdata,
    input  logic                    master_readdatavalid,
    input  logic                    master_waitrequest,
    output logic [1:0]              grant,
    input  logic                    timeout_clear,
    output logic                    timeout_flag
);

    typedef enum logic [1:0] {IDLE, CMD, RD_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    req0, req1;
    logic                    g_read, g_write;
    logic [ADDRESSWIDTH-1:0] g_address;
    logic [DATAWIDTH-1:0]    g_writedata;
    logic                    timeout_fire;
    logic                    rsp_valid;
    logic [DATAWIDTH-1:0]    rsp_data;

    assign req0        = r0_read | r0_write;
    assign req1        = r1_read | r1_write;
    assign g_read      = grant_q[1] ? r1_read      : r0_read;
    assign g_write     = grant_q[1] ? r1_write     : r0_write;
    assign g_address   = grant_q[1] ? r1_address   : r0_address;
    assign g_writedata = grant_q[1] ? r1_writedata : r0_writedata;
    assign grant       = grant_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // last_grant is committed at command acceptance rather than at grant time, so an
    // abandoned command leaves the tie-break unchanged; ties are only resolved in IDLE.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = CMD;
                    if (req0 && req1) grant_d = last_grant_q ? 2'b01 : 2'b10;
                    else              grant_d = req0 ? 2'b01 : 2'b10;
                end
            end
            CMD: begin
                if (!g_read && !g_write) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (!master_waitrequest) begin
                    last_grant_d = grant_q[1];
                    if (g_read) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            RD_WAIT: begin
                if (master_readdatavalid || timeout_fire) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        r0_waitrequest   = 1'b1;
        r1_waitrequest   = 1'b1;
        rsp_valid        = 1'b0;
        case (state_q)
            CMD: begin
                if (g_read || g_write) begin
                    master_read      = g_read;
                    master_write     = g_write & ~g_read;
                    master_address   = g_address;
                    master_writedata = g_writedata;
                end
                r0_waitrequest = grant_q[0] ? master_waitrequest : 1'b1;
                r1_waitrequest = grant_q[1] ? master_waitrequest : 1'b1;
            end
            RD_WAIT: rsp_valid = master_readdatavalid | timeout_fire;
            default: ;
        endcase
    end

    assign rsp_data         = timeout_fire ? DATAWIDTH'(32'hDEADDEAD) : master_readdata;
    assign r0_readdata      = rsp_data;
    assign r1_readdata      = rsp_data;
    assign r0_readdatavalid = rsp_valid & grant_q[0];
    assign r1_readdatavalid = rsp_valid & grant_q[1];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WDT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             timeout_flag_q, timeout_flag_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdt_q          <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            wdt_q          <= wdt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    // Counter idles at zero outside RD_WAIT, so each read wait starts from a cleared count.
    always_comb begin
        timeout_fire   = (state_q == RD_WAIT) && !master_readdatavalid &&
                         (wdt_q == WDT_W'(TIMEOUT_CYCLES - 1));
        wdt_d          = (state_q == RD_WAIT) ? wdt_q + 1'b1 : '0;
        timeout_flag_d = timeout_flag_q;
        if (timeout_fire)       timeout_flag_d = 1'b1;
        else if (timeout_clear) timeout_flag_d = 1'b0;
    end

    assign timeout_flag = timeout_flag_q;
`else
    logic unused_timeout_cfg;

    assign timeout_fire       = 1'b0;
    assign timeout_flag       = 1'b0;
    assign unused_timeout_cfg = timeout_clear ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_avm_master_arbiter.sv
// Scoreboard bench for avm_master_arbiter: downstream commands and routed read data are
// checked against expectations queued as stimulus is driven.
`timescale 1ns/1ps
module tb_avm_master_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] r0_address, r1_address, master_address;
  logic [DW-1:0] r0_writedata, r1_writedata, master_writedata;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic          r0_waitrequest, r1_waitrequest;
  logic [DW-1:0] r0_readdata, r1_readdata, master_readdata;
  logic          r0_readdatavalid, r1_readdatavalid;
  logic          master_read, master_write, master_readdatavalid, master_waitrequest;
  logic [1:0]    grant;
  logic          timeout_clear, timeout_flag;

  avm_master_arbiter #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_address(r0_address), .r0_writedata(r0_writedata), .r0_read(r0_read), .r0_write(r0_write),
    .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_writedata(r1_writedata), .r1_read(r1_read), .r1_write(r1_write),
    .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_read(master_read), .master_write(master_write),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest), .grant(grant),
    .timeout_clear(timeout_clear), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          exp_cmd[$];
  logic [DW-1:0] exp_rd0[$];
  logic [DW-1:0] exp_rd1[$];
  cmd_t          got;
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: downstream command acceptance and per-requester read data.
  always @(negedge clk) begin
    if (reset_n) begin
      if ((master_read || master_write) && !master_waitrequest) begin
        check("sb_cmd_pending", exp_cmd.size() != 0, 1'b1);
        if (exp_cmd.size() != 0) begin
          got = exp_cmd.pop_front();
          check("sb_cmd_wr", master_write, got.wr);
          check("sb_cmd_rd", master_read, !got.wr);
          check("sb_cmd_addr", master_address, got.addr);
          if (got.wr) check("sb_cmd_data", master_writedata, got.data);
        end
      end
      if (r0_readdatavalid) begin
        check("sb_rd0_pending", exp_rd0.size() != 0, 1'b1);
        if (exp_rd0.size() != 0) check("sb_rd0_data", r0_readdata, exp_rd0.pop_front());
      end
      if (r1_readdatavalid) begin
        check("sb_rd1_pending", exp_rd1.size() != 0, 1'b1);
        if (exp_rd1.size() != 0) check("sb_rd1_data", r1_readdata, exp_rd1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    r0_address = '0; r0_writedata = '0; r0_read = 1'b0; r0_write = 1'b0;
    r1_address = '0; r1_writedata = '0; r1_read = 1'b0; r1_write = 1'b0;
    master_readdata = '0; master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
    timeout_clear = 1'b0;
    cyc(); cyc();
    sample();
    check("rst_grant", grant, 2'b00);
    check("rst_r0_wait", r0_waitrequest, 1'b1);
    check("rst_r1_wait", r1_waitrequest, 1'b1);
    check("rst_mread", master_read, 1'b0);
    check("rst_mwrite", master_write, 1'b0);
    check("rst_maddr", master_address, '0);
    check("rst_mwdata", master_writedata, '0);
    check("rst_valid", {r0_readdatavalid, r1_readdatavalid}, 2'b00);
    check("rst_flag", timeout_flag, 1'b0);
    cyc();
    reset_n = 1'b1;

    // Single write
    r0_address = 26'h0500000; r0_writedata = 32'h000000AB; r0_write = 1'b1;
    exp_cmd.push_back('{1'b1, 26'h0500000, 32'h000000AB});
    sample();
    check("wr_idle_grant", grant, 2'b00);
    check("wr_idle_mwrite", master_write, 1'b0);
    cyc(); sample();
    check("wr_cmd_grant", grant, 2'b01);
    check("wr_cmd_mwrite", master_write, 1'b1);
    check("wr_cmd_r0_wait", r0_waitrequest, 1'b0);
    check("wr_cmd_r1_wait", r1_waitrequest, 1'b1);
    cyc(); r0_write = 1'b0; sample();
    check("wr_done_grant", grant, 2'b00);
    check("wr_done_mwrite", master_write, 1'b0);
    check("wr_done_maddr", master_address, '0);

    // Read with latency
    cyc();
    r1_address = 26'h0001000; r1_read = 1'b1;
    exp_cmd.push_back('{1'b0, 26'h0001000, 32'h0});
    exp_rd1.push_back(32'h11223344);
    sample();
    check("rd_idle_grant", grant, 2'b00);
    cyc(); sample();
    check("rd_cmd_grant", grant, 2'b10);
    check("rd_cmd_r1_wait", r1_waitrequest, 1'b0);
    cyc(); r1_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("rd_wait_valid", r1_readdatavalid, 1'b0);
      check("rd_wait_r1_wait", r1_waitrequest, 1'b1);
      cyc();
    end
    master_readdatavalid = 1'b1; master_readdata = 32'h11223344;
    sample();
    check("rd_r1_valid", r1_readdatavalid, 1'b1);
    check("rd_r0_valid", r0_readdatavalid, 1'b0);
    cyc(); master_readdatavalid = 1'b0; sample();
    check("rd_done_grant", grant, 2'b00);
    check("rd_done_valid", r1_readdatavalid, 1'b0);

    // Tie fairness with continuous reads
    cyc(); do_reset();
    r0_address = 26'h0000100; r0_read = 1'b1;
    r1_address = 26'h0000200; r1_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("rr_idle_grant", grant, 2'b00);
      cyc();
      if (k % 2 == 0) begin
        exp_cmd.push_back('{1'b0, 26'h0000100, 32'h0});
        exp_rd0.push_back(32'hC0DE0000 + k);
      end else begin
        exp_cmd.push_back('{1'b0, 26'h0000200, 32'h0});
        exp_rd1.push_back(32'hC0DE0000 + k);
      end
      sample();
      check("rr_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      master_readdatavalid = 1'b1; master_readdata = 32'hC0DE0000 + k;
      sample();
      check("rr_other_valid", (k % 2 == 0) ? r1_readdatavalid : r0_readdatavalid, 1'b0);
      cyc();
      master_readdatavalid = 1'b0;
    end
    r0_read = 1'b0; r1_read = 1'b0;

    // Waitrequest stall
    cyc(); do_reset();
    master_waitrequest = 1'b1;
    r0_address = 26'h0000123; r0_writedata = 32'h00000055; r0_write = 1'b1;
    r1_address = 26'h0000456; r1_read = 1'b1;
    exp_cmd.push_back('{1'b1, 26'h0000123, 32'h00000055});
    sample();
    check("st_idle_grant", grant, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cyc(); sample();
      check("st_grant", grant, 2'b01);
      check("st_maddr", master_address, 26'h0000123);
      check("st_mwdata", master_writedata, 32'h00000055);
      check("st_mwrite", master_write, 1'b1);
      check("st_r0_wait", r0_waitrequest, 1'b1);
      check("st_r1_wait", r1_waitrequest, 1'b1);
    end
    cyc(); master_waitrequest = 1'b0; sample();
    check("st_accept_r0_wait", r0_waitrequest, 1'b0);
    check("st_accept_grant", grant, 2'b01);
    cyc(); r0_write = 1'b0;
    exp_cmd.push_back('{1'b0, 26'h0000456, 32'h0});
    exp_rd1.push_back(32'h00000077);
    sample();
    check("st_idle2_grant", grant, 2'b00);
    cyc(); sample();
    check("st_r1_grant", grant, 2'b10);
    cyc(); r1_read = 1'b0;
    master_readdatavalid = 1'b1; master_readdata = 32'h00000077;
    sample();
    check("st_r1_valid", r1_readdatavalid, 1'b1);
    cyc(); master_readdatavalid = 1'b0;

    // Abandon keeps the tie-break with r0
    do_reset();
    master_waitrequest = 1'b1;
    r0_address = 26'h0000010; r0_writedata = 32'h1; r0_write = 1'b1;
    r1_address = 26'h0000020; r1_writedata = 32'h2; r1_write = 1'b1;
    sample();
    check("ab_idle_grant", grant, 2'b00);
    cyc(); sample();
    check("ab_cmd_grant", grant, 2'b01);
    cyc(); r0_write = 1'b0; sample();
    check("ab_drop_grant", grant, 2'b01);
    check("ab_drop_mwrite", master_write, 1'b0);
    check("ab_drop_maddr", master_address, '0);
    cyc(); r0_write = 1'b1; sample();
    check("ab_idle2_grant", grant, 2'b00);
    cyc();
    master_waitrequest = 1'b0;
    exp_cmd.push_back('{1'b1, 26'h0000010, 32'h1});
    sample();
    check("ab_regrant_r0", grant, 2'b01);
    cyc();
    exp_cmd.push_back('{1'b1, 26'h0000020, 32'h2});
    sample();
    check("ab_idle3_grant", grant, 2'b00);
    cyc(); sample();
    check("ab_next_r1", grant, 2'b10);
    cyc(); r0_write = 1'b0; r1_write = 1'b0;

    // Reset while in RD_WAIT, then a late valid
    r0_address = 26'h0000030; r0_read = 1'b1;
    exp_cmd.push_back('{1'b0, 26'h0000030, 32'h0});
    sample();
    cyc(); sample();
    check("rs_cmd_grant", grant, 2'b01);
    cyc(); r0_read = 1'b0; sample();
    check("rs_rdwait_grant", grant, 2'b01);
    check("rs_rdwait_valid", r0_readdatavalid, 1'b0);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    master_readdatavalid = 1'b1; master_readdata = 32'hBADBAD00;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rs_late_valid", {r0_readdatavalid, r1_readdatavalid}, 2'b00);
      check("rs_late_grant", grant, 2'b00);
      cyc();
    end
    master_readdatavalid = 1'b0;

`ifdef ARB_TIMEOUT_EN
    r0_address = 26'h0000040; r0_read = 1'b1;
    exp_cmd.push_back('{1'b0, 26'h0000040, 32'h0});
    sample();
    cyc(); sample();
    check("to_cmd_grant", grant, 2'b01);
    cyc(); r0_read = 1'b0;
    for (int i = 1; i < 16; i++) begin
      sample();
      check("to_wait_valid", r0_readdatavalid, 1'b0);
      check("to_wait_flag", timeout_flag, 1'b0);
      cyc();
    end
    exp_rd0.push_back(32'hDEADDEAD);
    sample();
    check("to_pulse", r0_readdatavalid, 1'b1);
    cyc(); sample();
    check("to_flag_set", timeout_flag, 1'b1);
    check("to_idle_grant", grant, 2'b00);
    check("to_pulse_once", r0_readdatavalid, 1'b0);
    cyc(); cyc(); sample();
    check("to_flag_sticky", timeout_flag, 1'b1);
    timeout_clear = 1'b1;
    cyc(); timeout_clear = 1'b0; sample();
    check("to_flag_cleared", timeout_flag, 1'b0);
`else
    sample();
    check("to_flag_tied", timeout_flag, 1'b0);
`endif

    cyc(); cyc();
    check("sb_cmd_drained", exp_cmd.size(), 0);
    check("sb_rd0_drained", exp_rd0.size(), 0);
    check("sb_rd1_drained", exp_rd1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
